// File: rtl/bpm_button_scheduler.sv
// Tempo-button front end: sync + debounce four buttons, fixed-priority grant, auto-repeat, clamped BPM register.
// Latency: press sampled at edge 0 updates o_bpm / pulses o_bpm_changed at edge DEBOUNCE_CYCLES+3.
// Backpressure: none; o_bpm_changed is a one-cycle strobe that downstream logic must take when it fires.
module bpm_button_scheduler #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int BPM_MIN         = 30,
  parameter int BPM_MAX         = 300,
  parameter int BPM_INIT        = 120
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_plus_1,
  input  logic       i_btn_plus_5,
  input  logic       i_btn_minus_1,
  input  logic       i_btn_minus_5,
  output logic [8:0] o_bpm,
  output logic       o_bpm_changed,
  output logic [3:0] o_grant
);

  // Counters compare against "limit - 1" because the transition edge itself is the last counted cycle.
  localparam logic [31:0] DEB_LAST = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] RD_LAST  = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RP_LAST  = 32'(REPEAT_PERIOD - 1);
  localparam logic [9:0]  MIN10    = 10'(BPM_MIN);
  localparam logic [9:0]  MAX10    = 10'(BPM_MAX);
  localparam logic [8:0]  INIT9    = 9'(BPM_INIT);

  typedef enum logic [2:0] {IDLE, DEBOUNCE, STEP, HOLD, RELEASE} state_t;

  state_t      state, state_next;
  logic [3:0]  raw, sync_a, sync_b;
  logic [3:0]  grant, grant_next, pick;
  logic [31:0] cnt, cnt_next;
  logic        first, first_next;
  logic        step_en;
  logic        granted_high;
  logic [31:0] hold_limit;
  logic [9:0]  bpm_wide, step_amt, bpm_new;

  // Bit order {minus_5, minus_1, plus_5, plus_1} matches o_grant.
  assign raw = {i_btn_minus_5, i_btn_minus_1, i_btn_plus_5, i_btn_plus_1};

  // Two-flop synchroniser per raw button.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  assign granted_high = |(sync_b & grant);
  assign hold_limit   = first ? RD_LAST : RP_LAST;
  assign o_grant      = (state == IDLE) ? 4'b0000 : grant;

  // Fixed priority pick: minus_5 > minus_1 > plus_5 > plus_1.
  always_comb begin
    pick = 4'b0001;
    if (sync_b[3])      pick = 4'b1000;
    else if (sync_b[2]) pick = 4'b0100;
    else if (sync_b[1]) pick = 4'b0010;
  end

  // FSM state, grant, shared counter and first-repeat flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      grant <= '0;
      cnt   <= '0;
      first <= 1'b0;
    end else begin
      state <= state_next;
      grant <= grant_next;
      cnt   <= cnt_next;
      first <= first_next;
    end
  end

  // Next-state logic; the counter is cleared on every state change so each state counts from zero.
  always_comb begin
    state_next = state;
    grant_next = grant;
    cnt_next   = cnt;
    first_next = first;
    step_en    = 1'b0;
    case (state)
      IDLE: begin
        if (|sync_b) begin
          grant_next = pick;
          cnt_next   = '0;
          state_next = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!granted_high) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else if (cnt == DEB_LAST) begin
          cnt_next   = '0;
          first_next = 1'b1;
          state_next = STEP;
        end else begin
          cnt_next = cnt + 32'd1;
        end
      end
      STEP: begin
        step_en    = 1'b1;
        cnt_next   = '0;
        state_next = HOLD;
      end
      HOLD: begin
        // Release takes precedence over a repeat that would fire on the same cycle.
        if (!granted_high) begin
          cnt_next   = '0;
          state_next = RELEASE;
        end else if (cnt == hold_limit) begin
          cnt_next   = '0;
          first_next = 1'b0;
          state_next = STEP;
        end else begin
          cnt_next = cnt + 32'd1;
        end
      end
      RELEASE: begin
        // Any button, granted or not, must be quiet before a new press is arbitrated.
        if (|sync_b) begin
          cnt_next = '0;
        end else if (cnt == DEB_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 32'd1;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Clamped step in 10 bits; subtraction is guarded so it can never wrap below BPM_MIN.
  always_comb begin
    bpm_wide = {1'b0, o_bpm};
    step_amt = (grant[1] | grant[3]) ? 10'd5 : 10'd1;
    bpm_new  = bpm_wide;
    if (grant[0] | grant[1]) begin
      bpm_new = ((bpm_wide + step_amt) > MAX10) ? MAX10 : (bpm_wide + step_amt);
    end else if (grant[2] | grant[3]) begin
      bpm_new = (bpm_wide < (MIN10 + step_amt)) ? MIN10 : (bpm_wide - step_amt);
    end
  end

  // BPM register and change strobe; a clamped no-op step leaves both untouched.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_bpm         <= INIT9;
      o_bpm_changed <= 1'b0;
    end else if (step_en && (bpm_new != bpm_wide)) begin
      o_bpm         <= bpm_new[8:0];
      o_bpm_changed <= 1'b1;
    end else begin
      o_bpm_changed <= 1'b0;
    end
  end

endmodule

// File: doc/bpm_button_scheduler.md
Name: bpm_button_scheduler

Overview:
- Front-end controller for the metronome BPM datapath.
- Synchronises and debounces the four tempo buttons (+1, +5, −1, −5).
- Arbitrates simultaneous presses and generates auto-repeat steps while a button is held.
- Maintains the clamped BPM value; issues a one-cycle change strobe consumed by downstream period/counter logic.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a press or a release.
- REPEAT_DELAY, 25000000: cycles from first step to first auto-repeat step.
- REPEAT_PERIOD, 5000000: cycles between subsequent auto-repeat steps.
- BPM_MIN, 30: lower clamp.
- BPM_MAX, 300: upper clamp; must be ≤ 511.
- BPM_INIT, 120: value after reset; BPM_MIN ≤ BPM_INIT ≤ BPM_MAX.

Ports:
- i_clk  input  1  system clock.
- i_reset  input  1  asynchronous, active-high reset.
- i_btn_plus_1  input  1  raw button, active-high, asynchronous to i_clk.
- i_btn_plus_5  input  1  raw button, active-high, asynchronous to i_clk.
- i_btn_minus_1  input  1  raw button, active-high, asynchronous to i_clk.
- i_btn_minus_5  input  1  raw button, active-high, asynchronous to i_clk.
- o_bpm  output  9  current BPM, unsigned.
- o_bpm_changed  output  1  one-cycle pulse, coincident with the first cycle o_bpm holds a new value.
- o_grant  output  4  one-hot granted button {minus_5, minus_1, plus_5, plus_1}; 0 when idle.

Behaviour:
- Reset (async, active-high):
  - o_bpm = BPM_INIT; o_bpm_changed = 0; o_grant = 0.
  - Synchronisers cleared, counters cleared, FSM = IDLE.
  - Reset asserted mid-operation aborts any pending or repeating step; no strobe is emitted.
- Synchronisation: each raw input passes through a 2-flop synchroniser; all FSM decisions use synchronised levels only.
- Arbitration, evaluated in IDLE only:
  - Fixed priority minus_5 > minus_1 > plus_5 > plus_1.
  - Grant is latched and held until the FSM returns to IDLE.
  - Non-granted buttons are ignored while a grant is held.
- FSM states:
  - IDLE: o_grant = 0. If any sync button is high, latch the grant, clear the counter, go to DEBOUNCE.
  - DEBOUNCE: counter increments each cycle the granted sync level is high. If it drops before DEBOUNCE_CYCLES, go to IDLE with no step. On the DEBOUNCE_CYCLES-th consecutive high cycle, go to STEP.
  - STEP (one cycle): apply the step at the next edge, clear the counter, go to HOLD.
  - HOLD: counter runs. If the granted sync level goes low, go to RELEASE. When the counter reaches the limit, go to STEP. The limit is REPEAT_DELAY after the first step and REPEAT_PERIOD after each repeat step.
  - RELEASE: requires all four sync buttons low for DEBOUNCE_CYCLES consecutive cycles; any high restarts the count. Then go to IDLE.
- Step arithmetic:
  - Compute in 10 bits: new = o_bpm ± {1 or 5}, clamped to [BPM_MIN, BPM_MAX]. No wrap-around.
  - If the clamped result equals the current o_bpm, o_bpm is unchanged, no o_bpm_changed pulse, and the FSM still proceeds normally.
- Latency: a raw press first sampled high at edge 0 and held stable produces o_bpm update plus o_bpm_changed at edge DEBOUNCE_CYCLES+3.
- Auto-repeat steps occur at edges:
  - first step + REPEAT_DELAY+1;
  - then every REPEAT_PERIOD+1 edges after that (the extra cycle is the STEP state).
- o_bpm_changed is never high on two consecutive cycles.

Test Plan:
Parameters for all tests: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, BPM_MIN=30, BPM_MAX=300, BPM_INIT=120.
- Reset: assert i_reset at arbitrary phase → o_bpm=120, o_bpm_changed=0, o_grant=0 immediately, without a clock edge.
- Single press: i_btn_plus_1 high for 10 cycles, then low → exactly one o_bpm_changed pulse at edge 7; o_bpm=121; o_grant=0001 until the release debounce completes, then 0.
- Glitch rejection: i_btn_plus_5 high for 3 cycles → no pulse, o_bpm stays 120, FSM returns to IDLE.
- Auto-repeat: i_btn_minus_5 held for 62 cycles → pulses at edges 7, 28, 37, 46, 55; o_bpm ends at 95.
- Simultaneous press: i_btn_plus_1 and i_btn_minus_1 rise together; release minus_1 after 10 cycles while plus_1 stays high 20 more cycles → o_grant=0100, a single step to 119, and no +1 step while plus_1 is still held.
- Clamp and reset mid-hold:
  - From o_bpm=298, press plus_5 → 300 with a pulse.
  - Press plus_5 again → 300 with no pulse.
  - Hold minus_1 and assert i_reset in HOLD → o_bpm=120, no further pulses.
